// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 character LCD blocks.
// Command bytes, default timings and init sequencer state encoding.
package lcd_pkg;

    // HD44780 command bytes
    localparam logic [7:0] CMD_WAKE       = 8'h30;
    localparam logic [7:0] CMD_FUNC_8B2L  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_DISP_BLINK = 8'h0F;
    localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_LINE2      = 8'hC0;

    // Default timings in clk cycles at 50 MHz
    localparam int T_POWERUP_DEF = 1_000_000;
    localparam int T_WAKE1_DEF   = 205_000;
    localparam int T_WAKE2_DEF   = 5_000;
    localparam int T_CMD_DEF     = 2_500;
    localparam int T_CLEAR_DEF   = 100_000;
    localparam int EN_PULSE_DEF  = 20;
    localparam int CNT_W_DEF     = 21;

    // Init sequence length
    localparam logic [2:0] LAST_STEP = 3'd6;

    // Init sequencer state encoding
    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_PULSE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        S_POWERUP = ST_POWERUP,
        S_SETUP   = ST_SETUP,
        S_PULSE   = ST_PULSE,
        S_WAIT    = ST_WAIT,
        S_DONE    = ST_DONE
    } init_state_t;

endpackage

// File: rtl/lcd_init_rom.sv
// Init step table: step index -> command byte and post-command wait.
// LCD_CURSOR_BLINK_EN selects a blinking cursor for the display-on step.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int T_WAKE1 = T_WAKE1_DEF,
    parameter int T_WAKE2 = T_WAKE2_DEF,
    parameter int T_CMD   = T_CMD_DEF,
    parameter int T_CLEAR = T_CLEAR_DEF
) (
    input  logic [2:0]       step,
    output logic [7:0]       cmd,
    output logic [CNT_W-1:0] dly
);

    localparam logic [CNT_W-1:0] D_WAKE1 = CNT_W'(T_WAKE1);
    localparam logic [CNT_W-1:0] D_WAKE2 = CNT_W'(T_WAKE2);
    localparam logic [CNT_W-1:0] D_CMD   = CNT_W'(T_CMD);
    localparam logic [CNT_W-1:0] D_CLEAR = CNT_W'(T_CLEAR);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] CMD_DISPLAY = CMD_DISP_BLINK;
`else
    localparam logic [7:0] CMD_DISPLAY = CMD_DISP_ON;
`endif

    // Decode the step index into its command and wait time
    always_comb begin
        cmd = CMD_CLEAR;
        dly = D_CLEAR;
        case (step)
            3'd0: begin
                cmd = CMD_WAKE;
                dly = D_WAKE1;
            end
            3'd1: begin
                cmd = CMD_WAKE;
                dly = D_WAKE2;
            end
            3'd2: begin
                cmd = CMD_WAKE;
                dly = D_CMD;
            end
            3'd3: begin
                cmd = CMD_FUNC_8B2L;
                dly = D_CMD;
            end
            3'd4: begin
                cmd = CMD_DISPLAY;
                dly = D_CMD;
            end
            3'd5: begin
                cmd = CMD_ENTRY_INC;
                dly = D_CMD;
            end
            default: begin
                cmd = CMD_CLEAR;
                dly = D_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/lcd_init_seq.sv
// HD44780 8-bit power-on init sequencer; re-runnable via restart.
// Build option LCD_CURSOR_BLINK_EN (in lcd_init_rom) enables cursor blink.
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = T_POWERUP_DEF,
    parameter int T_WAKE1   = T_WAKE1_DEF,
    parameter int T_WAKE2   = T_WAKE2_DEF,
    parameter int T_CMD     = T_CMD_DEF,
    parameter int T_CLEAR   = T_CLEAR_DEF,
    parameter int EN_PULSE  = EN_PULSE_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_PULSE - 1);

    init_state_t      state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_d;
    logic [7:0]       data_d;
    logic             done_d;
    logic             busy_d;

    logic [7:0]       rom_cmd;
    logic [CNT_W-1:0] rom_dly;
    logic [CNT_W-1:0] dly_last;

    lcd_init_rom #(
        .CNT_W  (CNT_W),
        .T_WAKE1(T_WAKE1),
        .T_WAKE2(T_WAKE2),
        .T_CMD  (T_CMD),
        .T_CLEAR(T_CLEAR)
    ) u_rom (
        .step(step_q),
        .cmd (rom_cmd),
        .dly (rom_dly)
    );

    assign dly_last = rom_dly - CNT_W'(1);

    // State and registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_POWERUP;
            step_q    <= 3'd0;
            cnt_q     <= '0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_data  <= 8'h00;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_en    <= en_d;
            lcd_data  <= data_d;
            init_done <= done_d;
            busy      <= busy_d;
        end
    end

    // Next state; en rises on leaving SETUP so it is high exactly in PULSE
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        en_d    = lcd_en;
        data_d  = lcd_data;
        done_d  = init_done;
        busy_d  = busy;
        unique case (state_q)
            S_POWERUP: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETUP: begin
                data_d  = rom_cmd;
                en_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == dly_last) begin
                    cnt_d = '0;
                    if (step_q == LAST_STEP) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                en_d = 1'b0;
                if (restart) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    step_d  = 3'd0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            default: begin
                en_d    = 1'b0;
                cnt_d   = '0;
                step_d  = 3'd0;
                state_d = S_POWERUP;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Self-checking bench for lcd_init_seq using small timing parameters.
// Expected pulses are queued from the step table and matched on en fall.
module tb_lcd_init_seq;
    import lcd_pkg::*;

    localparam int TP  = 10;
    localparam int EN  = 2;
    localparam int TC  = 5;
    localparam int TCL = 8;
    localparam int TW1 = 6;
    localparam int TW2 = 4;
    localparam int CW  = 21;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_en, init_done, busy;
    logic [7:0] lcd_data;

    lcd_init_seq #(
        .T_POWERUP(TP),
        .T_WAKE1  (TW1),
        .T_WAKE2  (TW2),
        .T_CMD    (TC),
        .T_CLEAR  (TCL),
        .EN_PULSE (EN),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .init_done(init_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        int         wt;
    } step_t;

    typedef struct {
        logic [7:0] data;
        int         rise;
        int         fall;
    } pulse_t;

    step_t  tbl[7];
    pulse_t sb[$];
    pulse_t got;
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     rise_c = 0;
    logic   en_q = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Edge count since reset release; edge k leaves cyc == k
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pulse monitor: each en fall pops one expected pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            en_q = 1'b0;
        end else begin
            if (lcd_en && !en_q) rise_c = cyc;
            if (!lcd_en && en_q) begin
                chk("rs_low", {31'd0, lcd_rs}, 32'd0);
                chk("rw_low", {31'd0, lcd_rw}, 32'd0);
                chk("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("pulse_data", {24'd0, lcd_data}, {24'd0, got.data});
                    chk("pulse_rise", rise_c, got.rise);
                    chk("pulse_fall", cyc, got.fall);
                end
            end
            en_q = lcd_en;
        end
    end

    function automatic int seq_len(input int p);
        int n = p;
        for (int i = 0; i < 7; i++) n += 1 + EN + tbl[i].wt;
        return n;
    endfunction

    task automatic push_seq(input int start, input int p);
        pulse_t e;
        int     t;
        t = start + p + 1;
        for (int i = 0; i < 7; i++) begin
            e.data = tbl[i].cmd;
            e.rise = t;
            e.fall = t + EN;
            sb.push_back(e);
            t += 1 + EN + tbl[i].wt;
        end
    endtask

    task automatic wait_done(input int exp_c, input string nm);
        int n = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, {31'd0, init_done}, 32'd1);
        chk({nm, "_cyc"}, cyc, exp_c);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_data"}, {24'd0, lcd_data}, 32'h01);
        chk({nm, "_en"}, {31'd0, lcd_en}, 32'd0);
        chk({nm, "_left"}, sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int n;
        tbl[0] = '{CMD_WAKE, TW1};
        tbl[1] = '{CMD_WAKE, TW2};
        tbl[2] = '{CMD_WAKE, TC};
        tbl[3] = '{CMD_FUNC_8B2L, TC};
`ifdef LCD_CURSOR_BLINK_EN
        tbl[4] = '{CMD_DISP_BLINK, TC};
`else
        tbl[4] = '{CMD_DISP_ON, TC};
`endif
        tbl[5] = '{CMD_ENTRY_INC, TC};
        tbl[6] = '{CMD_CLEAR, TCL};

        assert (TP > 0 && EN > 0 && TC > 0 && TCL > 0 && TW1 > 0 && TW2 > 0)
        else $fatal(1, "FAIL params: zero timing parameter");

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_en", {31'd0, lcd_en}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'h00);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        // Free run from reset release
        rst_n = 1'b1;
        push_seq(0, TP);
        wait_done(seq_len(TP), "run1");

        // One-cycle restart from done: no power-up delay
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        r = cyc;
        chk("restart_drop", {31'd0, init_done}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        push_seq(r, 0);
        wait_done(r + seq_len(0), "restart");

        // Restart held high throughout a busy run is ignored
        rst_n = 1'b0;
        restart = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        push_seq(0, TP);
        wait_done(seq_len(TP), "hold");
        restart = 1'b0;
        @(negedge clk);
        chk("hold_stay_done", {31'd0, init_done}, 32'd1);

        // Async reset in the middle of the step-3 pulse
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        push_seq(0, TP);
        n = 0;
        while (!(lcd_en && lcd_data == CMD_FUNC_8B2L) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("mid_found", {31'd0, lcd_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_en", {31'd0, lcd_en}, 32'd0);
        chk("async_done", {31'd0, init_done}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd1);
        chk("async_data", {24'd0, lcd_data}, 32'h00);
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        push_seq(0, TP);
        wait_done(seq_len(TP), "rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
